// File: rtl/alu_mdu_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring divider,
// one bit per cycle, with valid/ready handshakes on both sides.
module alu_mdu_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [31:0]      inst,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             illegal,
    output logic             div_zero,
    output logic [2:0]       dbg_state
);
    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // in_ready is high only in IDLE, out_valid only in DONE, and DONE holds until taken.
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {S_IDLE, S_PREP, S_CALC, S_FIX, S_DONE} state_t;
    state_t state, state_nxt;

    logic [WIDTH-1:0]   a_r, b_r, x_r;
    logic [2:0]         f3_r;
    logic [2*WIDTH-1:0] acc;
    logic               neg_r;
    logic [CW-1:0]      cnt;

    logic             accept, legal_in, dz_in, ovf_in, fast_in, unused_inst;
    logic [2:0]       f3_in;
    logic [WIDTH-1:0] fast_res;

    assign accept      = in_valid & in_ready;
    assign f3_in       = inst[14:12];
    assign legal_in    = (inst[6:0] == 7'b0110011) && (inst[31:25] == 7'b0000001);
    assign dz_in       = f3_in[2] && (b == '0);
    assign ovf_in      = f3_in[2] && !f3_in[0] && (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);
    assign fast_in     = !legal_in || dz_in || ovf_in;
    assign unused_inst = ^{inst[24:15], inst[11:7]};

    always_comb begin
        fast_res = '0;
        if (!legal_in)  fast_res = '0;
        else if (dz_in) fast_res = f3_in[1] ? a : '1;
        else if (ovf_in) fast_res = f3_in[1] ? '0 : a;
    end

    // Operand signedness: MULH/MULHSU treat a as signed, MULH also b; DIV/REM both.
    logic             signed_a, signed_b, sign_a, sign_b, neg;
    logic [WIDTH-1:0] a_mag, b_mag;

    assign signed_a = f3_r[2] ? !f3_r[0] : ((f3_r[1:0] == 2'b01) || (f3_r[1:0] == 2'b10));
    assign signed_b = f3_r[2] ? !f3_r[0] : (f3_r[1:0] == 2'b01);
    assign sign_a   = signed_a & a_r[WIDTH-1];
    assign sign_b   = signed_b & b_r[WIDTH-1];
    assign a_mag    = sign_a ? -a_r : a_r;
    assign b_mag    = sign_b ? -b_r : b_r;
    assign neg      = (f3_r[2] && f3_r[1]) ? sign_a : (sign_a ^ sign_b);

    // acc holds {high, multiplier} for multiply and {remainder, dividend/quotient} for divide.
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;
    logic [WIDTH-1:0]   mul_field, div_raw, div_field;

    always_comb begin
        mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, x_r} : '0);
        mul_next  = {mul_sum, acc[WIDTH-1:1]};
        rem_sh    = acc[2*WIDTH-1:WIDTH-1];
        diff      = rem_sh - {1'b0, x_r};
        div_next  = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        prod      = neg_r ? -acc : acc;
        mul_field = (f3_r[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
        div_raw   = f3_r[1] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
        div_field = neg_r ? -div_raw : div_raw;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) state_nxt = fast_in ? S_DONE : S_PREP;
            S_PREP: state_nxt = S_CALC;
            S_CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = S_FIX;
            S_FIX:  state_nxt = S_DONE;
            S_DONE: if (out_ready) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            a_r      <= '0;
            b_r      <= '0;
            x_r      <= '0;
            f3_r     <= '0;
            acc      <= '0;
            neg_r    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            illegal  <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: if (accept) begin
                    a_r      <= a;
                    b_r      <= b;
                    f3_r     <= f3_in;
                    illegal  <= !legal_in;
                    div_zero <= legal_in && dz_in;
                    if (fast_in) result <= fast_res;
                end
                S_PREP: begin
                    x_r   <= f3_r[2] ? b_mag : a_mag;
                    acc   <= {{WIDTH{1'b0}}, (f3_r[2] ? a_mag : b_mag)};
                    neg_r <= neg;
                    cnt   <= '0;
                end
                S_CALC: begin
                    acc <= f3_r[2] ? div_next : mul_next;
                    cnt <= cnt + CW'(1);
                end
                S_FIX: result <= f3_r[2] ? div_field : mul_field;
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == S_IDLE);
    assign out_valid = (state == S_DONE);
    assign dbg_state = state;

endmodule

// File: tb/tb_alu_mdu_seq.sv
// Bench for alu_mdu_seq: fixed and random RV32M requests at WIDTH=32 and WIDTH=16,
// checked against an arithmetic reference model.
module tb_alu_mdu_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, tb_in_valid, tb_out_ready, sel16;
    logic [31:0] a_in, b_in, inst_in;

    logic        in_ready_32, out_valid_32, illegal_32, div_zero_32;
    logic        in_ready_16, out_valid_16, illegal_16, div_zero_16;
    logic [31:0] result_32;
    logic [15:0] result_16;
    logic [2:0]  unused_dbg_32, unused_dbg_16;

    alu_mdu_seq #(.WIDTH(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .in_valid(tb_in_valid & !sel16), .in_ready(in_ready_32),
        .a(a_in), .b(b_in), .inst(inst_in), .out_valid(out_valid_32),
        .out_ready(tb_out_ready & !sel16), .result(result_32), .illegal(illegal_32),
        .div_zero(div_zero_32), .dbg_state(unused_dbg_32)
    );

    alu_mdu_seq #(.WIDTH(16)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(tb_in_valid & sel16), .in_ready(in_ready_16),
        .a(a_in[15:0]), .b(b_in[15:0]), .inst(inst_in), .out_valid(out_valid_16),
        .out_ready(tb_out_ready & sel16), .result(result_16), .illegal(illegal_16),
        .div_zero(div_zero_16), .dbg_state(unused_dbg_16)
    );

    logic        cur_in_ready, cur_out_valid, cur_illegal, cur_div_zero;
    logic [63:0] cur_result;
    assign cur_in_ready  = sel16 ? in_ready_16  : in_ready_32;
    assign cur_out_valid = sel16 ? out_valid_16 : out_valid_32;
    assign cur_illegal   = sel16 ? illegal_16   : illegal_32;
    assign cur_div_zero  = sel16 ? div_zero_16  : div_zero_32;
    assign cur_result    = sel16 ? {48'd0, result_16} : {32'd0, result_32};

    int          checks = 0;
    int          errors = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] mk(input longint v, input int w);
        logic [63:0] mask;
        mask = (64'd1 << w) - 64'd1;
        return 64'(v) & mask;
    endfunction

    function automatic logic [31:0] m_inst(input logic [2:0] f3);
        logic [4:0] rs1, rs2, rd;
        rs1 = 5'($urandom_range(0, 31));
        rs2 = 5'($urandom_range(0, 31));
        rd  = 5'($urandom_range(0, 31));
        return {7'b0000001, rs2, rs1, f3, rd, 7'b0110011};
    endfunction

    // Reference: exact integer arithmetic on wide signed values, truncating division.
    task automatic ref_model(input int w, input logic [31:0] inst, input logic [63:0] a,
                             input logic [63:0] b, output logic [63:0] res,
                             output logic ill, output logic dz, output int lat);
        logic signed [127:0] ua, ub, sa, sb, p, q, r, t;
        logic [63:0]         mask;
        logic [2:0]          f3;
        mask = (64'd1 << w) - 64'd1;
        ua   = $signed({64'd0, a & mask});
        ub   = $signed({64'd0, b & mask});
        sa   = a[w-1] ? ua - (128'sd1 <<< w) : ua;
        sb   = b[w-1] ? ub - (128'sd1 <<< w) : ub;
        f3   = inst[14:12];
        ill  = !((inst[6:0] == 7'h33) && (inst[31:25] == 7'h01));
        dz   = 1'b0;
        lat  = w + 2;
        res  = '0;
        p    = '0;
        if (ill) begin
            lat = 0;
        end else if (!f3[2]) begin
            case (f3[1:0])
                2'b00: p = ua * ub;
                2'b01: p = sa * sb;
                2'b10: p = sa * ub;
                default: p = ua * ub;
            endcase
            t   = (f3[1:0] == 2'b00) ? p : (p >>> w);
            res = t[63:0] & mask;
        end else if (ub == 0) begin
            dz  = 1'b1;
            lat = 0;
            res = f3[1] ? (a & mask) : mask;
        end else begin
            if (!f3[0]) begin
                q = sa / sb;
                r = sa % sb;
                if (sa == -(128'sd1 <<< (w - 1)) && sb == -128'sd1) lat = 0;
            end else begin
                q = ua / ub;
                r = ua % ub;
            end
            t   = f3[1] ? r : q;
            res = t[63:0] & mask;
        end
    endtask

    // Fast-path requests enter DONE on the accept edge itself, so out_valid is seen in
    // the cycle right after accept; normal ops need w+2 further edges.
    task automatic run_op(input string tag, input int w, input logic [31:0] inst,
                          input logic [63:0] a, input logic [63:0] b, input int hold);
        logic [63:0] er, got;
        logic        eill, edz;
        int          elat, lat;
        ref_model(w, inst, a, b, er, eill, edz, elat);
        exp_q.push_back(er);
        @(negedge clk);
        sel16 = (w == 16);
        #1;
        check({tag, ".in_ready_idle"}, cur_in_ready, 1);
        a_in = a[31:0]; b_in = b[31:0]; inst_in = inst; tb_in_valid = 1'b1;
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
        a_in = $urandom; b_in = $urandom; inst_in = $urandom;
        lat = 0;
        while (!cur_out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, ".latency"}, 64'(lat), 64'(elat));
        got = exp_q.pop_front();
        check({tag, ".result"}, cur_result, got);
        check({tag, ".illegal"}, cur_illegal, eill);
        check({tag, ".div_zero"}, cur_div_zero, edz);
        for (int i = 0; i < hold; i++) begin
            a_in = $urandom; b_in = $urandom; inst_in = m_inst(3'($urandom_range(0, 7)));
            tb_in_valid = 1'b1;
            @(posedge clk); #1;
            tb_in_valid = 1'b0;
            check({tag, ".hold_result"}, cur_result, er);
            check({tag, ".hold_valid"}, cur_out_valid, 1);
            check({tag, ".hold_in_ready"}, cur_in_ready, 0);
        end
        tb_out_ready = 1'b1;
        @(posedge clk); #1;
        tb_out_ready = 1'b0;
        check({tag, ".released_valid"}, cur_out_valid, 0);
        check({tag, ".released_ready"}, cur_in_ready, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".ov32"}, out_valid_32, 0);
        check({tag, ".ir32"}, in_ready_32, 1);
        check({tag, ".res32"}, result_32, 0);
        check({tag, ".ill32"}, illegal_32, 0);
        check({tag, ".dz32"}, div_zero_32, 0);
        check({tag, ".ov16"}, out_valid_16, 0);
        check({tag, ".ir16"}, in_ready_16, 1);
        check({tag, ".res16"}, result_16, 0);
    endtask

    initial begin
        rst_n = 1'b0; tb_in_valid = 1'b0; tb_out_ready = 1'b0; sel16 = 1'b0;
        a_in = '0; b_in = '0; inst_in = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int wi = 0; wi < 2; wi++) begin
            int w;
            w = (wi == 0) ? 32 : 16;
            run_op("mul_7_m3",     w, m_inst(3'b000), mk(7, w),      mk(-3, w), 0);
            run_op("mulhu_m1_m1",  w, m_inst(3'b011), mk(-1, w),     mk(-1, w), 0);
            run_op("mulhsu_m1_2",  w, m_inst(3'b010), mk(-1, w),     mk(2, w),  0);
            run_op("mulh_m5_3",    w, m_inst(3'b001), mk(-5, w),     mk(3, w),  0);
            run_op("div_m7_2",     w, m_inst(3'b100), mk(-7, w),     mk(2, w),  0);
            run_op("rem_m7_2",     w, m_inst(3'b110), mk(-7, w),     mk(2, w),  0);
            run_op("divu_100_7",   w, m_inst(3'b101), mk(100, w),    mk(7, w),  0);
            run_op("remu_100_7",   w, m_inst(3'b111), mk(100, w),    mk(7, w),  5);
            run_op("divu_by_zero", w, m_inst(3'b101), mk(16'h1234, w), 64'd0,   0);
            run_op("rem_by_zero",  w, m_inst(3'b110), mk(16'h1234, w), 64'd0,   0);
            run_op("div_ovf",      w, m_inst(3'b100), 64'd1 << (w - 1), mk(-1, w), 0);
            run_op("rem_ovf",      w, m_inst(3'b110), 64'd1 << (w - 1), mk(-1, w), 0);
            run_op("illegal_addi", w, 32'h0000_0013,  mk(9, w),      mk(4, w),  2);
        end

        // Reset in the middle of a multiply; the previous op leaves a nonzero result.
        run_op("pre_reset_divu", 32, m_inst(3'b101), 64'd100, 64'd7, 0);
        @(negedge clk);
        sel16 = 1'b0;
        a_in = 32'hdead_beef; b_in = 32'h1234_5678; inst_in = m_inst(3'b001);
        tb_in_valid = 1'b1;
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check_reset_outputs("mid_calc_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_3_5", 32, m_inst(3'b000), 64'd3, 64'd5, 0);

        for (int i = 0; i < 48; i++) begin
            int          w;
            logic [31:0] inst;
            logic [63:0] ra, rb;
            w = (i % 2 == 0) ? 32 : 16;
            inst = m_inst(3'($urandom_range(0, 7)));
            if ($urandom_range(0, 7) == 0) begin
                inst = $urandom;
                if (inst[6:0] == 7'h33 && inst[31:25] == 7'h01) inst[25] = 1'b0;
            end
            case ($urandom_range(0, 5))
                0: ra = 64'd0;
                1: ra = 64'd1 << (w - 1);
                2: ra = mk(-1, w);
                3: ra = 64'($urandom_range(0, 20));
                default: ra = mk(longint'($urandom), w);
            endcase
            case ($urandom_range(0, 5))
                0: rb = 64'd0;
                1: rb = mk(-1, w);
                2: rb = 64'($urandom_range(1, 9));
                default: rb = mk(longint'($urandom), w);
            endcase
            run_op("random", w, inst, ra, rb, $urandom_range(0, 2));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
